// File: rtl/frame_load_pkg.sv
// Shared types for the frame load sequencer: FSM state encoding and header field positions.
package frame_load_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    STROBE = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  // Header layout: column index in the top bits, frame index in the bottom bits.
  localparam int HDR_FRAME_LSB = 0;

  function automatic int hdr_col_msb(input int frame_bits);
    return frame_bits - 1;
  endfunction

endpackage

// File: rtl/frame_load_sequencer_if.sv
// Input word stream of the frame load sequencer (valid/ready word channel).
interface frame_load_sequencer_if #(
  parameter int FRAME_BITS = 32
);
  // A word transfers on a clock edge where valid && ready; data is held
  // stable while valid is high and ready is low.
  logic                  valid;
  logic                  ready;
  logic [FRAME_BITS-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/frame_load_sequencer.sv
// Loads NUM_ROWS row slices after a header word, then strobes one frame in one or all columns.
// Optional check word after the data is enabled by defining FRAME_LOAD_CHECK_EN.
module frame_load_sequencer
  import frame_load_pkg::*;
#(
  parameter int NUM_ROWS   = 8,
  parameter int NUM_COLS   = 10,
  parameter int FRAME_BITS = 32,
  parameter int MAX_FRAMES = 20
) (
  input  logic                           CLK,
  input  logic                           resetn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FRAME_BITS-1:0]          in_data,
  output logic [FRAME_BITS*NUM_ROWS-1:0] FrameData,
  output logic [MAX_FRAMES*NUM_COLS-1:0] FrameStrobe,
  input  logic                           err_clr,
  output logic                           err,
  output logic                           busy,
  output logic [15:0]                    frames_done,
  output state_t                         state
);

  localparam int COL_W = $clog2(NUM_COLS + 1);
  localparam int IDX_W = $clog2(MAX_FRAMES);
  localparam int CNT_W = $clog2(NUM_ROWS + 2);
  localparam int HDR_COL_MSB = hdr_col_msb(FRAME_BITS);
`ifdef FRAME_LOAD_CHECK_EN
  localparam int DRAIN_WORDS = NUM_ROWS + 1;
`else
  localparam int DRAIN_WORDS = NUM_ROWS;
`endif

  localparam logic [COL_W-1:0] BCAST_COL  = '1;
  localparam logic [COL_W-1:0] NUM_COLS_C = COL_W'(NUM_COLS);

  state_t             state_n;
  logic [CNT_W-1:0]   row_cnt, row_n;
  logic [COL_W-1:0]   col_q;
  logic [IDX_W-1:0]   frame_q;
  logic               bcast_q;
  logic               accept, ld_hdr, wr_row, err_set;
  logic [COL_W-1:0]   hdr_col;
  logic [IDX_W-1:0]   hdr_frame;
  logic               hdr_bcast, hdr_bad;
`ifdef FRAME_LOAD_CHECK_EN
  logic [FRAME_BITS-1:0] chk_q;
`endif

  assign hdr_col   = in_data[HDR_COL_MSB -: COL_W];
  assign hdr_frame = in_data[HDR_FRAME_LSB +: IDX_W];
  assign hdr_bcast = (hdr_col == BCAST_COL);
  assign hdr_bad   = (!hdr_bcast && (hdr_col >= NUM_COLS_C)) ||
                     ({1'b0, hdr_frame} >= (IDX_W+1)'(MAX_FRAMES));
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n  = state;
    row_n    = row_cnt;
    ld_hdr   = 1'b0;
    wr_row   = 1'b0;
    err_set  = 1'b0;
    in_ready = (state != STROBE);
    case (state)
      IDLE: if (accept) begin
        ld_hdr = 1'b1;
        row_n  = '0;
        if (hdr_bad) begin
          err_set = 1'b1;
          state_n = DRAIN;
        end else begin
          state_n = LOAD;
        end
      end
      LOAD: if (accept) begin
        wr_row = 1'b1;
        if (row_cnt == CNT_W'(NUM_ROWS - 1)) begin
          row_n = '0;
`ifdef FRAME_LOAD_CHECK_EN
          state_n = CHECK;
`else
          state_n = STROBE;
`endif
        end else begin
          row_n = row_cnt + 1'b1;
        end
      end
`ifdef FRAME_LOAD_CHECK_EN
      CHECK: if (accept) begin
        if (in_data != chk_q) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = STROBE;
        end
      end
`endif
      STROBE: state_n = IDLE;
      DRAIN: if (accept) begin
        if (row_cnt == CNT_W'(DRAIN_WORDS - 1)) begin
          row_n   = '0;
          state_n = IDLE;
        end else begin
          row_n = row_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      row_cnt     <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      bcast_q     <= 1'b0;
      FrameData   <= '0;
      frames_done <= '0;
      err         <= 1'b0;
`ifdef FRAME_LOAD_CHECK_EN
      chk_q       <= '0;
`endif
    end else begin
      state   <= state_n;
      row_cnt <= row_n;
      // Set wins over clear so an error in the clearing cycle is not lost.
      err     <= err_set | (err & ~err_clr);
      if (ld_hdr && !hdr_bad) begin
        col_q   <= hdr_col;
        frame_q <= hdr_frame;
        bcast_q <= hdr_bcast;
      end
      if (wr_row) FrameData[row_cnt*FRAME_BITS +: FRAME_BITS] <= in_data;
      if (state == STROBE) frames_done <= frames_done + 16'd1;
`ifdef FRAME_LOAD_CHECK_EN
      if (ld_hdr) chk_q <= in_data;
      else if (wr_row) chk_q <= chk_q ^ in_data;
`endif
    end
  end

  always_comb begin
    FrameStrobe = '0;
    if (state == STROBE) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        for (int f = 0; f < MAX_FRAMES; f++) begin
          if ((frame_q == IDX_W'(f)) && (bcast_q || (col_q == COL_W'(c))))
            FrameStrobe[c*MAX_FRAMES + f] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_load_sequencer.sv
// Table-driven and randomized bench for frame_load_sequencer against a word-level frame model.
module tb_frame_load_sequencer;
  import frame_load_pkg::*;

  localparam int NR = 8, NC = 10, FB = 32, MF = 20;
  localparam int SW = MF * NC;
  localparam int DW = FB * NR;

  logic            clk = 1'b0;
  logic            resetn;
  logic            err_clr;
  logic [DW-1:0]   frame_data;
  logic [SW-1:0]   frame_strobe;
  logic            err, busy;
  logic [15:0]     frames_done;
  state_t          state;

  frame_load_sequencer_if #(.FRAME_BITS(FB)) ifc ();

  frame_load_sequencer #(.NUM_ROWS(NR), .NUM_COLS(NC), .FRAME_BITS(FB), .MAX_FRAMES(MF)) dut (
    .CLK(clk), .resetn(resetn), .in_valid(ifc.valid), .in_ready(ifc.ready),
    .in_data(ifc.data), .FrameData(frame_data), .FrameStrobe(frame_strobe),
    .err_clr(err_clr), .err(err), .busy(busy), .frames_done(frames_done), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0]  exp_q[$];
  logic [DW-1:0]  m_data;
  logic [15:0]    m_done;
  logic           m_err;
  logic [FB-1:0]  data_w[NR];

  typedef struct {
    logic [31:0] hdr;
    int          gap;
    logic        exp_ok;
    int          exp_col;
    int          exp_frame;
    logic        exp_bc;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, expv);
    end
  endtask

  function automatic logic [SW-1:0] strobe_of(input int col, input int fr, input logic bc);
    logic [SW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++)
      if (bc || c == col) v[c*MF + fr] = 1'b1;
    return v;
  endfunction

  // Strobe scoreboard: every nonzero strobe cycle must match the next expected strobe.
  always @(negedge clk) begin
    if (resetn && frame_strobe != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got %h", frame_strobe);
      end else begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        if (frame_strobe !== e) begin
          errors++;
          $display("FAIL strobe_value got %h want %h", frame_strobe, e);
        end
      end
      checks++;
      if (ifc.ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL strobe_handshake ready %b busy %b want 0 1", ifc.ready, busy);
      end
    end
  end

  task automatic send_word(input logic [FB-1:0] d, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      ifc.valid = 1'b0;
    end
    @(negedge clk);
    ifc.valid = 1'b1;
    ifc.data  = d;
    n = 0;
    while (!ifc.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
    end
    @(posedge clk);
    #1 ifc.valid = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return $urandom_range(0, 2);
    return 0;
  endfunction

  task automatic run_frame(input logic [31:0] hdr, input int gap_mode, input logic bad_chk,
                           input logic ok, input int col, input int fr, input logic bc);
    logic [FB-1:0] x;
    if (ok && !bad_chk) exp_q.push_back(strobe_of(col, fr, bc));
    x = hdr;
    send_word(hdr, pick_gap(gap_mode));
    for (int k = 0; k < NR; k++) begin
      send_word(data_w[k], pick_gap(gap_mode));
      x = x ^ data_w[k];
    end
`ifdef FRAME_LOAD_CHECK_EN
    send_word(bad_chk ? (x ^ 32'h1) : x, pick_gap(gap_mode));
`endif
    repeat (3) @(posedge clk);
    #1;
    if (ok) begin
      for (int k = 0; k < NR; k++) m_data[k*FB +: FB] = data_w[k];
      if (!bad_chk) m_done = m_done + 16'd1;
    end
    if (!ok || bad_chk) m_err = 1'b1;
    chk("frame_data", frame_data, m_data);
    chk("frames_done", DW'(frames_done), DW'(m_done));
    chk("err", DW'(err), DW'(m_err));
    chk("strobe_issued", DW'(exp_q.size()), DW'(0));
    chk("busy_idle", DW'(busy), DW'(0));
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_cleared", DW'(err), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{32'h3000_0005, 0, 1'b1, 3, 5,  1'b0};
    vecs[1] = '{32'hF000_0002, 0, 1'b1, 0, 2,  1'b1};
    vecs[2] = '{32'hA000_0000, 0, 1'b0, 0, 0,  1'b0};
    vecs[3] = '{32'h9000_0013, 2, 1'b1, 9, 19, 1'b0};
    vecs[4] = '{32'h0000_0014, 0, 1'b0, 0, 0,  1'b0};
    vecs[5] = '{32'hF000_0013, 2, 1'b1, 0, 19, 1'b1};
    vecs[6] = '{32'hB000_0001, 2, 1'b0, 0, 0,  1'b0};
    vecs[7] = '{32'h3000_0005, 1, 1'b1, 3, 5,  1'b0};

    resetn = 1'b0;
    err_clr = 1'b0;
    ifc.valid = 1'b0;
    ifc.data = '0;
    m_data = '0;
    m_done = '0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame_data", frame_data, '0);
    chk("rst_strobe", DW'(frame_strobe), '0);
    chk("rst_err_busy_done", DW'({err, busy, frames_done}), '0);
    chk("rst_ready", DW'(ifc.ready), DW'(1));
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NR; k++)
        data_w[k] = (i == 0 || i == 7) ? FB'((k + 1) * 32'h11) : $urandom();
      run_frame(vecs[i].hdr, vecs[i].gap, 1'b0, vecs[i].exp_ok,
                vecs[i].exp_col, vecs[i].exp_frame, vecs[i].exp_bc);
      if (!vecs[i].exp_ok) clear_err();
    end

    // Error raised in the same cycle as err_clr must remain set.
    @(negedge clk);
    err_clr = 1'b1;
    send_word(32'hC000_0003, 0);
    err_clr = 1'b0;
    chk("err_set_over_clr", DW'(err), DW'(1));
    for (int k = 0; k < NR; k++) send_word($urandom(), 0);
`ifdef FRAME_LOAD_CHECK_EN
    send_word($urandom(), 0);
`endif
    repeat (2) @(posedge clk);
    #1 chk("drain_data_kept", frame_data, m_data);
    m_err = 1'b1;
    clear_err();

    // Reset in the middle of a load aborts the frame.
    send_word(32'h2000_0003, 0);
    for (int k = 0; k < 3; k++) send_word($urandom(), 0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_data", frame_data, '0);
    chk("midrst_strobe", DW'(frame_strobe), '0);
    chk("midrst_err_busy_done", DW'({err, busy, frames_done}), '0);
    m_data = '0;
    m_done = '0;
    m_err = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < NR; k++) data_w[k] = FB'((k + 1) * 32'h11);
    run_frame(32'h3000_0005, 0, 1'b0, 1'b1, 3, 5, 1'b0);

`ifdef FRAME_LOAD_CHECK_EN
    for (int k = 0; k < NR; k++) data_w[k] = $urandom();
    run_frame(32'h1000_0004, 0, 1'b1, 1'b1, 1, 4, 1'b0);
    clear_err();
    run_frame(32'h1000_0004, 0, 1'b0, 1'b1, 1, 4, 1'b0);
`endif

    // Randomized frames judged by the header rules directly.
    for (int i = 0; i < 12; i++) begin
      int col, fr;
      logic bc, ok;
      logic [31:0] hdr;
      col = $urandom_range(0, 15);
      fr  = $urandom_range(0, 31);
      hdr = $urandom();
      hdr[31:28] = 4'(col);
      hdr[4:0]   = 5'(fr);
      bc = (col == 15);
      ok = (bc || col < NC) && (fr < MF);
      for (int k = 0; k < NR; k++) data_w[k] = $urandom();
      run_frame(hdr, 2, 1'b0, ok, col, fr, bc);
      if (!ok) clear_err();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
